// File: rtl/wb_counter_bank_if.sv
// rtl/wb_counter_bank_if.sv - decoded Wishbone register bus for the counter bank
interface wb_counter_bank_if;
  logic        valid;
  logic [3:0]  wstrb;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, wstrb, addr, wdata, input rdata, ready);
  modport slave  (input valid, wstrb, addr, wdata, output rdata, ready);
endinterface

// File: rtl/wb_counter_bank.sv
// rtl/wb_counter_bank.sv - bank of CHANNELS up/down limit counters with per-channel irq
// Channel 0 COUNT can be forced from the logic analyzer; bus writes still take priority.
module wb_counter_bank #(
  parameter int BITS     = 32,
  parameter int CHANNELS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_counter_bank_if.slave         bus,
  input  logic [BITS-1:0]          i_la_write,
  input  logic [BITS-1:0]          i_la_input,
  output logic [CHANNELS*BITS-1:0] o_count_out,
  output logic [CHANNELS-1:0]      o_irq
);

  logic [BITS-1:0]     r_count [CHANNELS];
  logic [BITS-1:0]     r_limit [CHANNELS];
  logic [CHANNELS-1:0] r_en;
  logic [CHANNELS-1:0] r_down;
  logic [CHANNELS-1:0] r_oneshot;
  logic [CHANNELS-1:0] r_irq_en;
  logic [CHANNELS-1:0] r_status;
  logic                r_ready;
  logic [31:0]         r_rdata;

  logic                w_accept;
  logic                w_write;
  logic [1:0]          w_reg;
  logic [31:0]         w_wmask;
  logic [31:0]         w_rd_val;
  logic                w_la_active;
  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_ctrl_wr;
  logic [CHANNELS-1:0] w_count_wr;
  logic [CHANNELS-1:0] w_limit_wr;
  logic                w_unused;

  assign w_accept    = bus.valid & ~r_ready;
  assign w_write     = w_accept & (|bus.wstrb);
  assign w_reg       = bus.addr[3:2];
  assign w_la_active = |i_la_write;
  assign w_wmask     = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
  assign w_unused    = ^{bus.addr[1:0], bus.wdata, w_wmask};

  // Out-of-range channel indexes match no w_sel bit, so they read 0 and drop writes.
  always_comb begin
    w_sel      = '0;
    w_hit      = '0;
    w_ctrl_wr  = '0;
    w_count_wr = '0;
    w_limit_wr = '0;
    w_rd_val   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_sel[n]      = (bus.addr[7:4] == 4'(n));
      w_hit[n]      = r_down[n] ? (r_count[n] == '0) : (r_count[n] == r_limit[n]);
      w_ctrl_wr[n]  = w_write & w_sel[n] & (w_reg == 2'd0) & bus.wstrb[0];
      w_count_wr[n] = w_write & w_sel[n] & (w_reg == 2'd1);
      w_limit_wr[n] = w_write & w_sel[n] & (w_reg == 2'd2);
      if (w_sel[n]) begin
        case (w_reg)
          2'd0:    w_rd_val[4:0] = {r_status[n], r_irq_en[n], r_oneshot[n], r_down[n], r_en[n]};
          2'd1:    w_rd_val[BITS-1:0] = r_count[n];
          2'd2:    w_rd_val[BITS-1:0] = r_limit[n];
          default: w_rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_en      <= '0;
      r_down    <= '0;
      r_oneshot <= '0;
      r_irq_en  <= '0;
      r_status  <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_count[n] <= '0;
        r_limit[n] <= '1;
      end
    end else begin
      r_ready <= w_accept;
      if (w_accept && !w_write) r_rdata <= w_rd_val;

      for (int n = 0; n < CHANNELS; n++) begin
        if (w_count_wr[n]) begin
          r_count[n] <= (r_count[n] & ~w_wmask[BITS-1:0]) | (bus.wdata[BITS-1:0] & w_wmask[BITS-1:0]);
        end else if (n == 0 && w_la_active) begin
          r_count[n] <= i_la_write & i_la_input;
        end else if (r_en[n]) begin
          if (!w_hit[n]) begin
            r_count[n] <= r_down[n] ? r_count[n] - BITS'(1) : r_count[n] + BITS'(1);
          end else if (!r_oneshot[n]) begin
            r_count[n] <= r_down[n] ? r_limit[n] : '0;
          end
        end

        if (w_limit_wr[n]) begin
          r_limit[n] <= (r_limit[n] & ~w_wmask[BITS-1:0]) | (bus.wdata[BITS-1:0] & w_wmask[BITS-1:0]);
        end

        // A limit event in the same cycle as a W1C keeps STATUS set.
        if (r_en[n] && w_hit[n]) begin
          r_status[n] <= 1'b1;
        end else if (w_ctrl_wr[n] && bus.wdata[4]) begin
          r_status[n] <= 1'b0;
        end

        if (w_ctrl_wr[n]) begin
          r_en[n]      <= bus.wdata[0];
          r_down[n]    <= bus.wdata[1];
          r_oneshot[n] <= bus.wdata[2];
          r_irq_en[n]  <= bus.wdata[3];
        end else if (r_en[n] && w_hit[n] && r_oneshot[n]) begin
          r_en[n] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_count_out = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      o_count_out[n*BITS +: BITS] = r_count[n];
    end
  end

  assign o_irq     = r_status & r_irq_en;
  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;

endmodule

// File: tb/tb_wb_counter_bank.sv
// tb/tb_wb_counter_bank.sv - self-checking bench for wb_counter_bank
module tb_wb_counter_bank;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  la_write = '0;
  logic [31:0]  la_input = '0;
  logic [127:0] count_out;
  logic [3:0]   irq;
  int           checks = 0;
  int           errors = 0;

  wb_counter_bank_if bif();

  wb_counter_bank #(.BITS(32), .CHANNELS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bif),
    .i_la_write (la_write),
    .i_la_input (la_input),
    .o_count_out(count_out),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  // Reference model: one record per channel, CTRL kept as {STATUS,IRQ_EN,ONESHOT,DOWN,EN}.
  logic [31:0] m_cnt [4];
  logic [31:0] m_lim [4];
  logic [4:0]  m_ctl [4];
  logic        m_rdy;
  logic [31:0] m_rd;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt(input int c);
    return count_out[c*32 +: 32];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = 0;
      m_lim[c] = 32'hFFFF_FFFF;
      m_ctl[c] = 0;
    end
    m_rdy = 0;
    m_rd  = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    int c;
    c = int'(a[7:4]);
    if (c >= 4) return 32'd0;
    case (a[3:2])
      2'd0:    return {27'd0, m_ctl[c]};
      2'd1:    return m_cnt[c];
      2'd2:    return m_lim[c];
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] nc [4];
    logic [31:0] nl [4];
    logic [4:0]  nt [4];
    logic        acc, wr, hit;
    logic [31:0] mask;
    int          wc;
    if (reset) begin
      model_reset();
      return;
    end
    acc  = bif.valid && !m_rdy;
    wr   = acc && (bif.wstrb != 0);
    mask = {{8{bif.wstrb[3]}}, {8{bif.wstrb[2]}}, {8{bif.wstrb[1]}}, {8{bif.wstrb[0]}}};
    wc   = int'(bif.addr[7:4]);
    for (int c = 0; c < 4; c++) begin
      nc[c] = m_cnt[c];
      nl[c] = m_lim[c];
      nt[c] = m_ctl[c];
      hit   = 0;
      if (m_ctl[c][0]) begin
        if (m_ctl[c][1]) begin
          if (m_cnt[c] == 0) begin
            hit = 1;
            if (!m_ctl[c][2]) nc[c] = m_lim[c];
          end else nc[c] = m_cnt[c] - 1;
        end else begin
          if (m_cnt[c] == m_lim[c]) begin
            hit = 1;
            if (!m_ctl[c][2]) nc[c] = 0;
          end else nc[c] = m_cnt[c] + 1;
        end
        if (hit) begin
          nt[c][4] = 1;
          if (m_ctl[c][2]) nt[c][0] = 0;
        end
      end
      if (c == 0 && la_write != 0) nc[0] = la_write & la_input;
      if (wr && wc == c) begin
        case (bif.addr[3:2])
          2'd0: if (bif.wstrb[0]) begin
            nt[c][3:0] = bif.wdata[3:0];
            if (bif.wdata[4] && !hit) nt[c][4] = 0;
          end
          2'd1: nc[c] = (m_cnt[c] & ~mask) | (bif.wdata & mask);
          2'd2: nl[c] = (m_lim[c] & ~mask) | (bif.wdata & mask);
          default: ;
        endcase
      end
    end
    if (acc && !wr) m_rd = m_read(bif.addr);
    m_rdy = acc;
    for (int c = 0; c < 4; c++) begin
      m_cnt[c] = nc[c];
      m_lim[c] = nl[c];
      m_ctl[c] = nt[c];
    end
  endtask

  task automatic compare_all();
    logic [3:0] mi;
    for (int c = 0; c < 4; c++) begin
      chk("model_count", cnt(c), m_cnt[c]);
      mi[c] = m_ctl[c][4] & m_ctl[c][3];
    end
    chk("model_irq", {28'd0, irq}, {28'd0, mi});
    chk("model_ready", {31'd0, bif.ready}, {31'd0, m_rdy});
    chk("model_rdata", bif.rdata, m_rd);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    bif.valid = 1'b1;
    bif.addr  = a;
    bif.wdata = d;
    bif.wstrb = s;
  endtask

  task automatic idle();
    bif.valid = 1'b0;
    bif.wstrb = 4'd0;
  endtask

  task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(a, d, s);
    tick();
    chk("ack_high", {31'd0, bif.ready}, 32'd1);
    idle();
    tick();
    chk("ack_low", {31'd0, bif.ready}, 32'd0);
  endtask

  initial begin
    int up_cnt [5];
    int up_irq [5];
    int dn_cnt [4];
    up_cnt = '{1, 2, 3, 0, 1};
    up_irq = '{0, 0, 0, 1, 1};
    dn_cnt = '{1, 0, 0, 0};

    tbl[0]  = '{8'h18, 32'h0,         4'h0, 32'hFFFF_FFFF};
    tbl[1]  = '{8'h04, 32'h1122_3344, 4'hF, 32'h0};
    tbl[2]  = '{8'h04, 32'hAABB_CCDD, 4'h4, 32'h0};
    tbl[3]  = '{8'h04, 32'h0,         4'h0, 32'h11BB_3344};
    tbl[4]  = '{8'hF0, 32'h0,         4'h0, 32'h0};
    tbl[5]  = '{8'hF4, 32'hDEAD_BEEF, 4'hF, 32'h0};
    tbl[6]  = '{8'hF4, 32'h0,         4'h0, 32'h0};
    tbl[7]  = '{8'h38, 32'h1234_5678, 4'h3, 32'h0};
    tbl[8]  = '{8'h38, 32'h0,         4'h0, 32'hFFFF_5678};
    tbl[9]  = '{8'h3C, 32'hCAFE_F00D, 4'hF, 32'h0};
    tbl[10] = '{8'h3C, 32'h0,         4'h0, 32'h0};
    tbl[11] = '{8'h10, 32'hFFFF_FFEE, 4'hF, 32'h0};
    tbl[12] = '{8'h10, 32'h0,         4'h0, 32'h0000_000E};
    tbl[13] = '{8'h20, 32'h0000_00FF, 4'h2, 32'h0};
    tbl[14] = '{8'h20, 32'h0,         4'h0, 32'h0};
    tbl[15] = '{8'h00, 32'h0,         4'h0, 32'h0};

    bif.valid = 1'b0;
    bif.addr  = '0;
    bif.wdata = '0;
    bif.wstrb = '0;
    model_reset();
    tick();
    tick();
    chk("reset_irq", {28'd0, irq}, 32'd0);
    chk("reset_ready", {31'd0, bif.ready}, 32'd0);
    chk("reset_rdata", bif.rdata, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb);
      if (tbl[i].wstrb == 4'd0) chk($sformatf("table_read_%0d", i), bif.rdata, tbl[i].exp);
    end

    // Channel 0 up, periodic, LIMIT=3.
    bus(8'h08, 32'd3, 4'hF);
    bus(8'h04, 32'd0, 4'hF);
    drive(8'h00, 32'h09, 4'h1);
    tick();
    chk("up_enable_edge", cnt(0), 32'd0);
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("up_seq", cnt(0), 32'(up_cnt[i]));
      chk("up_irq", {31'd0, irq[0]}, 32'(up_irq[i]));
    end
    drive(8'h00, 32'h19, 4'h1);
    tick();
    chk("w1c_count", cnt(0), 32'd2);
    chk("w1c_irq", {31'd0, irq[0]}, 32'd0);
    idle();
    tick();
    chk("pre_hit_count", cnt(0), 32'd3);
    drive(8'h00, 32'h19, 4'h1);
    tick();
    chk("w1c_vs_set_irq", {31'd0, irq[0]}, 32'd1);
    chk("w1c_vs_set_count", cnt(0), 32'd0);
    idle();
    tick();

    // LA override on channel 0, then a same-cycle bus write wins.
    la_write = 32'hFF;
    la_input = 32'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("la_force", cnt(0), 32'hA5);
    end
    drive(8'h04, 32'h10, 4'hF);
    tick();
    chk("bus_over_la", cnt(0), 32'h10);
    idle();
    tick();
    chk("la_after_bus", cnt(0), 32'hA5);
    la_write = 32'h0;
    bus(8'h00, 32'h0, 4'h1);

    // Channel 2 down, one-shot.
    bus(8'h28, 32'd5, 4'hF);
    bus(8'h24, 32'd2, 4'hF);
    drive(8'h20, 32'h07, 4'h1);
    tick();
    chk("dn_enable_edge", cnt(2), 32'd2);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dn_seq", cnt(2), 32'(dn_cnt[i]));
    end
    bus(8'h20, 32'h0, 4'h0);
    chk("oneshot_ctrl", bif.rdata, 32'h16);
    chk("oneshot_irq_masked", {31'd0, irq[2]}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bif.valid = ($urandom_range(0, 1) == 1);
      bif.addr  = {($urandom_range(0, 5) == 5) ? 4'hF : 4'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'b00};
      bif.wdata = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      bif.wstrb = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
      la_write  = ($urandom_range(0, 9) == 0) ? ($urandom & 32'hFF) : 32'd0;
      la_input  = $urandom;
      tick();
    end
    idle();
    la_write = 32'h0;
    tick();

    // Asynchronous reset mid-count with a transaction outstanding.
    bus(8'h08, 32'd100, 4'hF);
    bus(8'h00, 32'h09, 4'h1);
    drive(8'h04, 32'h0, 4'h0);
    tick();
    chk("outstanding_ack", {31'd0, bif.ready}, 32'd1);
    reset = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) chk("async_rst_count", cnt(c), 32'd0);
    chk("async_rst_irq", {28'd0, irq}, 32'd0);
    chk("async_rst_ready", {31'd0, bif.ready}, 32'd0);
    chk("async_rst_rdata", bif.rdata, 32'd0);
    model_reset();
    idle();
    tick();
    reset = 1'b0;
    tick();
    bus(8'h18, 32'h0, 4'h0);
    chk("post_rst_limit", bif.rdata, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
